serial_pattern_transmitter: RTL and testbench

//   Bit-serial pattern source. Drives the single-bit line consumed by our

---
 rtl/serial_pattern_transmitter_pkg.sv | 19 +
 rtl/serial_pattern_transmitter_shift_out_register.sv | 28 ++
 rtl/serial_pattern_transmitter.sv | 137 +++++++++++++
 tb/tb_serial_pattern_transmitter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_transmitter_pkg.sv
// Shared definitions for the serial pattern transmitter.
// Holds the FSM encoding, the idle line level and a counter-width helper.
package serial_pattern_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic SERIAL_IDLE = 1'b1;

    // Bits needed to count num_values distinct values, never less than one bit.
    function automatic int counter_width(input int num_values);
        return (num_values <= 1) ? 1 : $clog2(num_values);
    endfunction

endpackage

// File: rtl/serial_pattern_transmitter_shift_out_register.sv
// Parallel-load, shift-left register presenting its MSB as the next serial bit.
// Load has priority over shift.
module serial_pattern_transmitter_shift_out_register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= load_data;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_transmitter.sv
// Bit-serial pattern source: sends a captured frame MSB first, load_repeat+1 times,
// with GAP idle-high cycles between repeats and a frame_done pulse at the end.
module serial_pattern_transmitter #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int REP_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [REP_W-1:0] load_repeat,
    output logic             serial_out,
    output logic             busy,
    output logic             frame_done
);

    import serial_pattern_transmitter_pkg::*;

    localparam int BIT_W = counter_width(WIDTH);
    localparam int GAP_W = counter_width(GAP + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    state_t           state;
    state_t           next_state;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_next;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_next;
    logic [WIDTH-1:0] frame_buf;
    logic             buf_load;
    logic             frame_done_next;
    logic             sreg_load;
    logic             sreg_shift;
    logic [WIDTH-1:0] sreg_data;
    logic             sreg_msb;

    serial_pattern_transmitter_shift_out_register #(
        .WIDTH(WIDTH)
    ) u_shift_out_register (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (sreg_load),
        .shift     (sreg_shift),
        .load_data (sreg_data),
        .msb       (sreg_msb)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            rep_cnt    <= '0;
            frame_buf  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            bit_cnt    <= bit_cnt_next;
            gap_cnt    <= gap_cnt_next;
            rep_cnt    <= rep_cnt_next;
            frame_done <= frame_done_next;
            if (buf_load) begin
                frame_buf <= load_data;
            end
        end
    end

    // Every re-entry to SHIFT reloads the shifter from frame_buf and consumes one repeat.
    always_comb begin
        next_state      = state;
        bit_cnt_next    = bit_cnt;
        gap_cnt_next    = gap_cnt;
        rep_cnt_next    = rep_cnt;
        buf_load        = 1'b0;
        frame_done_next = 1'b0;
        sreg_load       = 1'b0;
        sreg_shift      = 1'b0;
        sreg_data       = frame_buf;

        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    next_state   = ST_SHIFT;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    rep_cnt_next = load_repeat;
                    buf_load     = 1'b1;
                    sreg_load    = 1'b1;
                    sreg_data    = load_data;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    if (rep_cnt == '0) begin
                        next_state      = ST_IDLE;
                        frame_done_next = 1'b1;
                    end else if (GAP == 0) begin
                        bit_cnt_next = '0;
                        rep_cnt_next = rep_cnt - REP_W'(1);
                        sreg_load    = 1'b1;
                    end else begin
                        next_state   = ST_GAP;
                        gap_cnt_next = '0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + BIT_W'(1);
                    sreg_shift   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    next_state   = ST_SHIFT;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    rep_cnt_next = rep_cnt - REP_W'(1);
                    sreg_load    = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so reset forces the idle line without a clock.
    assign load_ready = (state == ST_IDLE);
    assign busy       = (state == ST_SHIFT) || (state == ST_GAP);
    assign serial_out = (state == ST_SHIFT) ? sreg_msb : SERIAL_IDLE;

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Scoreboard bench for serial_pattern_transmitter: frames are expanded into expected
// line bits when accepted, and a monitor pops and compares every busy cycle.
module tb_serial_pattern_transmitter;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
    localparam int REP_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic [REP_W-1:0] load_repeat;
    logic             load_ready;
    logic             serial_out;
    logic             busy;
    logic             frame_done;

    logic             z_valid;
    logic [WIDTH-1:0] z_data;
    logic [REP_W-1:0] z_repeat;
    logic             z_ready;
    logic             z_serial;
    logic             z_busy;
    logic             z_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    bit bit_q[$];
    int len_q[$];
    int run_len  = 0;
    bit done_exp = 1'b0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    serial_pattern_transmitter #(
        .WIDTH(WIDTH), .GAP(GAP), .REP_W(REP_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_repeat (load_repeat),
        .serial_out  (serial_out),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    serial_pattern_transmitter #(
        .WIDTH(WIDTH), .GAP(0), .REP_W(REP_W)
    ) dut_gap0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_valid  (z_valid),
        .load_ready  (z_ready),
        .load_data   (z_data),
        .load_repeat (z_repeat),
        .serial_out  (z_serial),
        .busy        (z_busy),
        .frame_done  (z_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: actual %0h required %0h", name, $time, actual, expected);
        end
    endtask

    // Reference model: a frame becomes rep+1 copies of its bits MSB first, GAP ones between copies.
    task automatic pushFrame(input logic [WIDTH-1:0] data, input int rep);
        for (int r = 0; r <= rep; r++) begin
            for (int k = WIDTH - 1; k >= 0; k--) bit_q.push_back(data[k]);
            if (r < rep) begin
                for (int g = 0; g < GAP; g++) bit_q.push_back(1'b1);
            end
        end
        len_q.push_back((rep + 1) * WIDTH + rep * GAP);
    endtask

    task automatic driveCycle(input bit v, input logic [WIDTH-1:0] d, input logic [REP_W-1:0] r,
                              output bit taken);
        @(negedge clock);
        load_valid  = v;
        load_data   = d;
        load_repeat = r;
        taken = v && (load_ready === 1'b1);
        if (taken) pushFrame(d, int'(r));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [REP_W-1:0] r);
        bit taken = 1'b0;
        bit dummy;
        int guard = 0;
        while (!taken && guard < 400) begin
            driveCycle(1'b1, d, r, taken);
            guard++;
        end
        checkOutput("handshake_accepted", 32'(taken), 32'd1);
        driveCycle(1'b0, WIDTH'($urandom), REP_W'($urandom), dummy);
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((len_q.size() != 0 || done_exp) && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("drain_pending_frames", 32'(len_q.size()), 32'd0);
    endtask

    task automatic zeroGapCheck(input logic [WIDTH-1:0] d, input logic [REP_W-1:0] r);
        @(negedge clock);
        z_valid  = 1'b1;
        z_data   = d;
        z_repeat = r;
        checkOutput("gap0_ready", 32'(z_ready), 32'd1);
        @(posedge clock);
        #2;
        z_valid = 1'b0;
        z_data  = ~d;
        for (int rr = 0; rr <= int'(r); rr++) begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                checkOutput("gap0_serial", 32'(z_serial), 32'(d[k]));
                checkOutput("gap0_busy", 32'(z_busy), 32'd1);
                @(posedge clock);
                #2;
            end
        end
        checkOutput("gap0_done", 32'(z_done), 32'd1);
        checkOutput("gap0_idle", 32'(z_busy), 32'd0);
        @(negedge clock);
    endtask

    // Monitor: shortly after each edge, compare the line against the head of the scoreboard.
    always @(posedge clock) begin
        bit exp_busy;
        bit exp_bit;
        #2;
        if (check_en) begin
            exp_busy = (len_q.size() != 0);
            checkOutput("busy", 32'(busy), 32'(exp_busy));
            checkOutput("load_ready", 32'(load_ready), 32'(!exp_busy));
            checkOutput("frame_done", 32'(frame_done), 32'(done_exp));
            done_exp = 1'b0;
            if (exp_busy && bit_q.size() != 0) begin
                exp_bit = bit_q.pop_front();
                checkOutput("serial_bit", 32'(serial_out), 32'(exp_bit));
                run_len++;
                if (run_len == len_q[0]) begin
                    void'(len_q.pop_front());
                    run_len  = 0;
                    done_exp = 1'b1;
                end
            end else begin
                checkOutput("serial_idle", 32'(serial_out), 32'd1);
            end
        end
    end

    initial begin
        bit dummy;
        reset_n     = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        load_repeat = '0;
        z_valid     = 1'b0;
        z_data      = '0;
        z_repeat    = '0;
        #1;
        checkOutput("reset_serial_out", 32'(serial_out), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_load_ready", 32'(load_ready), 32'd1);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        check_en = 1'b1;

        $display("[TB] single frame A5 and repeated frame 0F");
        applyStimulus(8'hA5, 4'd0);
        waitIdle();
        applyStimulus(8'h0F, 4'd2);
        waitIdle();
        applyStimulus(8'b0101_0000, 4'd0);
        waitIdle();

        $display("[TB] back-to-back frames and maximum repeat count");
        applyStimulus(8'h3C, 4'd1);
        applyStimulus(8'hC3, 4'd0);
        waitIdle();
        applyStimulus(8'h81, 4'd15);
        waitIdle();

        $display("[TB] random frames");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(WIDTH'($urandom), REP_W'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) waitIdle();
        end
        waitIdle();

        $display("[TB] load_valid held high with changing data");
        for (int c = 0; c < 200; c++) begin
            driveCycle(1'b1, WIDTH'($urandom), REP_W'($urandom_range(0, 3)), dummy);
        end
        driveCycle(1'b0, '0, '0, dummy);
        waitIdle();

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(8'h00, 4'd3);
        repeat (4) @(negedge clock);
        check_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midframe_reset_serial_out", 32'(serial_out), 32'd1);
        checkOutput("midframe_reset_busy", 32'(busy), 32'd0);
        checkOutput("midframe_reset_load_ready", 32'(load_ready), 32'd1);
        checkOutput("midframe_reset_frame_done", 32'(frame_done), 32'd0);
        bit_q.delete();
        len_q.delete();
        run_len  = 0;
        done_exp = 1'b0;
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        check_en = 1'b1;
        applyStimulus(8'h96, 4'd1);
        waitIdle();

        $display("[TB] zero-gap instance");
        zeroGapCheck(8'hF0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            zeroGapCheck(WIDTH'($urandom), REP_W'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
